// File: rtl/branch_predictor.sv
// branch_predictor: next-PC generator for the fetch stage.
// Direct-mapped BTB with 2-bit saturating direction counters, trained by
// resolved branches from EX. Next-PC priority: redirect, jump, predicted
// target, sequential. Optional statistics counters are built only when
// BP_STATS_EN is defined; otherwise stat_updates/stat_mispred read 0.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        isjump,
  input  logic [31:0] jump_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispred,
  output logic        predict,
  output logic [31:0] pcresult,
  output logic [31:0] stat_updates,
  output logic [31:0] stat_mispred
);

  localparam int TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag_mem    [ENTRIES];
  logic [31:0]        target_mem [ENTRIES];
  logic [1:0]         ctr_mem    [ENTRIES];

  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] tag;
  logic [TAG_W-1:0] upd_tag;
  logic             hit;
  logic             upd_hit;

  assign idx     = pc[IDX_W+1:2];
  assign tag     = pc[31:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[31:IDX_W+2];

  assign hit     = valid[idx] && (tag_mem[idx] == tag);
  assign upd_hit = valid[upd_idx] && (tag_mem[upd_idx] == upd_tag);
  assign predict = hit && ctr_mem[idx][1];

  // Next fetch PC with fixed priority; sequential path wraps modulo 2^32.
  always_comb begin
    pcresult = pc + 32'd4;
    if (redirect)     pcresult = redirect_pc;
    else if (isjump)  pcresult = jump_target;
    else if (predict) pcresult = target_mem[idx];
  end

  // BTB/counter training from resolved branches; lookups see the old entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid      <= '0;
      tag_mem    <= '{default: '0};
      target_mem <= '{default: '0};
      ctr_mem    <= '{default: 2'd1};
    end else if (upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          if (ctr_mem[upd_idx] != 2'd3) ctr_mem[upd_idx] <= ctr_mem[upd_idx] + 2'd1;
          target_mem[upd_idx] <= upd_target;
        end else begin
          if (ctr_mem[upd_idx] != 2'd0) ctr_mem[upd_idx] <= ctr_mem[upd_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        valid[upd_idx]      <= 1'b1;
        tag_mem[upd_idx]    <= upd_tag;
        target_mem[upd_idx] <= upd_target;
        ctr_mem[upd_idx]    <= 2'd2;
      end
    end
  end

`ifdef BP_STATS_EN
  logic unused_bits;
  assign unused_bits = ^{pc[1:0], upd_pc[1:0]};

  // Saturating counts of resolved branches and of flagged mispredictions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_updates <= '0;
      stat_mispred <= '0;
    end else if (upd_valid) begin
      if (stat_updates != '1) stat_updates <= stat_updates + 32'd1;
      if (upd_mispred && (stat_mispred != '1)) stat_mispred <= stat_mispred + 32'd1;
    end
  end
`else
  logic unused_bits;
  assign unused_bits  = ^{pc[1:0], upd_pc[1:0], upd_mispred};
  assign stat_updates = '0;
  assign stat_mispred = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed vectors for branch_predictor with a
// scoreboard queue of expected {predict, pcresult, stat_updates, stat_mispred}
// drained by an independent monitor process.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = 32'h100;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        isjump = 1'b0;
  logic [31:0] jump_target = '0;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_mispred = 1'b0;
  logic        predict;
  logic [31:0] pcresult;
  logic [31:0] stat_updates;
  logic [31:0] stat_mispred;

  branch_predictor #(.ENTRIES(16), .IDX_W(4)) dut (
    .clk(clk), .rst(rst), .pc(pc),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .isjump(isjump), .jump_target(jump_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispred(upd_mispred),
    .predict(predict), .pcresult(pcresult),
    .stat_updates(stat_updates), .stat_mispred(stat_mispred)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [96:0] exp_q[$];
  string       name_q[$];
  event        sample_ev;

  // Expected statistics: count of updates/mispredicts issued since reset.
  int unsigned exp_upd = 0;
  int unsigned exp_mis = 0;

  task automatic check(input string name, input logic p, input logic [31:0] npc);
    logic [31:0] su;
    logic [31:0] sm;
`ifdef BP_STATS_EN
    su = exp_upd;
    sm = exp_mis;
`else
    su = '0;
    sm = '0;
`endif
    exp_q.push_back({p, npc, su, sm});
    name_q.push_back(name);
    #1;
    -> sample_ev;
    #1;
  endtask

  task automatic do_update(input logic [31:0] a, input logic t,
                           input logic [31:0] tg, input logic m);
    upd_valid   = 1'b1;
    upd_pc      = a;
    upd_taken   = t;
    upd_target  = tg;
    upd_mispred = m;
    @(posedge clk);
    #1;
    upd_valid   = 1'b0;
    upd_mispred = 1'b0;
    exp_upd++;
    if (m) exp_mis++;
    @(negedge clk);
  endtask

  // Monitor: compare every output snapshot announced against the queue head.
  initial begin
    logic [96:0] e;
    logic [96:0] a;
    string n;
    forever begin
      @(sample_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        a = {predict, pcresult, stat_updates, stat_mispred};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL %s: got predict=%b pcresult=%h upd=%0d mis=%0d, want predict=%b pcresult=%h upd=%0d mis=%0d",
                   n, a[96], a[95:64], a[63:32], a[31:0], e[96], e[95:64], e[63:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, total=%0d", total);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state, checked while reset is held and after release.
    #2;
    check("reset_held", 1'b0, 32'h104);
    @(negedge clk);
    rst = 1'b0;
    check("reset_idle", 1'b0, 32'h104);

    // Train 0x100 taken -> 0x200; lookup during the write sees the old entry.
    upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h200;
    check("same_cycle_no_bypass", 1'b0, 32'h104);
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    exp_upd++;
    @(negedge clk);
    check("trained_hit", 1'b1, 32'h200);

    // Counter saturation at 3 then floor at 0.
    do_update(32'h100, 1'b1, 32'h200, 1'b0);   // 3
    do_update(32'h100, 1'b1, 32'h200, 1'b0);   // 3 (sat)
    check("ctr_sat_hi", 1'b1, 32'h200);
    do_update(32'h100, 1'b0, 32'h999, 1'b1);   // 2, target unchanged
    check("nt1_still_taken", 1'b1, 32'h200);
    do_update(32'h100, 1'b0, 32'h999, 1'b0);   // 1
    check("nt2_not_taken", 1'b0, 32'h104);
    do_update(32'h100, 1'b0, 32'h999, 1'b0);   // 0
    do_update(32'h100, 1'b0, 32'h999, 1'b0);   // 0 (floor)
    do_update(32'h100, 1'b1, 32'h240, 1'b0);   // 1
    check("ctr_floor", 1'b0, 32'h104);
    do_update(32'h100, 1'b1, 32'h240, 1'b0);   // 2, target refreshed
    check("target_refresh", 1'b1, 32'h240);

    // Aliasing: 0x140 shares index 0 with 0x100 but has a different tag.
    do_update(32'h140, 1'b1, 32'h500, 1'b0);
    pc = 32'h100;
    check("alias_evicted", 1'b0, 32'h104);
    pc = 32'h140;
    check("alias_new", 1'b1, 32'h500);

    // Miss with not-taken does not allocate.
    do_update(32'h180, 1'b0, 32'h700, 1'b0);
    pc = 32'h140;
    check("miss_nt_no_alloc", 1'b1, 32'h500);
    pc = 32'h180;
    check("miss_nt_lookup", 1'b0, 32'h184);

    // Priority: jump over prediction, redirect over everything.
    pc = 32'h140; isjump = 1'b1; jump_target = 32'h300;
    check("prio_jump", 1'b1, 32'h300);
    redirect = 1'b1; redirect_pc = 32'h400;
    check("prio_redirect", 1'b1, 32'h400);
    isjump = 1'b0;
    check("redirect_only", 1'b1, 32'h400);
    redirect = 1'b0;
    pc = 32'hFFFF_FFFC;
    check("pc_wrap", 1'b0, 32'h0);

    // Asynchronous reset between edges clears state without a clock edge.
    pc = 32'h140;
    rst = 1'b1;
    exp_upd = 0;
    exp_mis = 0;
    check("async_reset", 1'b0, 32'h144);
    rst = 1'b0;
    check("after_async_reset", 1'b0, 32'h144);

    // Update presented while reset is high is dropped.
    @(negedge clk);
    rst = 1'b1;
    upd_valid = 1'b1; upd_pc = 32'h140; upd_taken = 1'b1; upd_target = 32'h600;
    upd_mispred = 1'b1;
    @(posedge clk);
    #1;
    upd_valid = 1'b0; upd_mispred = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("upd_in_reset_dropped", 1'b0, 32'h144);

    // Statistics: 5 updates, 2 flagged mispredicted.
    do_update(32'h010, 1'b1, 32'h800, 1'b1);
    do_update(32'h014, 1'b0, 32'h800, 1'b0);
    do_update(32'h018, 1'b1, 32'h900, 1'b0);
    do_update(32'h010, 1'b0, 32'h800, 1'b1);
    do_update(32'h01C, 1'b0, 32'h800, 1'b0);
    pc = 32'h018;
    check("stats_and_hit", 1'b1, 32'h900);
    pc = 32'h010;
    check("stats_ctr_dec", 1'b0, 32'h014);

    #5;
    if (exp_q.size() != 0) begin
      bad++;
      total++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised next-PC generator for the pipelined CPU's fetch stage. Combines a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters. Selects the next fetch PC with fixed priority: execute-stage redirect, then decode-stage jump, then predicted-taken target, then sequential PC. Trained by resolved branches from the execute stage.

## Interface
Parameters:
- ENTRIES, 16: BTB/counter entries; power of two, 2..256.
- IDX_W, 4: log2(ENTRIES).
- TAG_W: derived as 30-IDX_W; not overridable.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- pc  input  32  current fetch PC, word aligned.
- redirect  input  1  EX mispredict, correct path known.
- redirect_pc  input  32  correct next PC from EX.
- isjump  input  1  ID-stage unconditional jump.
- jump_target  input  32  jump destination from ID.
- upd_valid  input  1  a branch resolved in EX this cycle.
- upd_pc  input  32  PC of the resolved branch.
- upd_taken  input  1  actual branch outcome.
- upd_target  input  32  actual taken target.
- upd_mispred  input  1  the prediction made for this branch was wrong (statistics only).
- predict  output  1  fetch lookup hit with counter >= 2.
- pcresult  output  32  next fetch PC.
- stat_updates  output  32  resolved-branch count (see Configuration).
- stat_mispred  output  32  mispredict count (see Configuration).

## Operation
- Lookup index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]. upd_pc is indexed and tagged the same way.
- Each entry holds: valid (1), tag (TAG_W), target (32), ctr (2).
- hit = valid && stored tag == pc tag. predict = hit && ctr[1].
- pcresult priority:
  - redirect: redirect_pc.
  - else isjump: jump_target.
  - else predict: stored target.
  - else pc+4, computed modulo 2^32 (0xFFFFFFFC wraps to 0).
- Update when upd_valid, entry addressed by upd_pc:
  - Hit, upd_taken=1: ctr saturating increment (max 3); target <= upd_target.
  - Hit, upd_taken=0: ctr saturating decrement (min 0); target unchanged.
  - Miss, upd_taken=1: allocate or replace the entry: valid=1, tag, target=upd_target, ctr=2.
  - Miss, upd_taken=0: no change.
- redirect, isjump and upd_valid are independent of each other and may all be asserted in the same cycle.

## Timing
- Lookup and pcresult are combinational from pc and the current state, within the same cycle.
- An update is written at the rising edge and is visible to lookups starting the following cycle.
- Lookup and update to the same index in the same cycle: the lookup sees the old entry; there is no bypass.
- Reset values:
  - All valid bits = 0; all ctr = 1 (weakly not-taken); targets and tags = 0.
  - Therefore predict = 0 and pcresult = pc+4 unless redirect or isjump is asserted.
  - Statistics counters = 0.
- Asserting rst mid-operation clears state immediately, without waiting for clk. Updates arriving while rst is high are dropped.

## Configuration
- BP_STATS_EN defined:
  - stat_updates increments on each cycle with upd_valid.
  - stat_mispred increments on each cycle with upd_valid && upd_mispred.
  - Both saturate at 0xFFFFFFFF and are cleared by rst.
- BP_STATS_EN undefined: no counter logic is built; stat_updates and stat_mispred are driven constant 0.

## Test plan
- Reset then pc=0x100, all controls low -> predict=0, pcresult=0x104. Pulse rst between clock edges -> state cleared with no clk edge.
- Update upd_pc=0x100, taken, target=0x200, one clk -> lookup pc=0x100 gives predict=1, pcresult=0x200. Same-cycle lookup during the update -> pcresult=0x104.
- Counter saturation: two taken updates, then not-taken updates -> predict stays 1 after the first not-taken, becomes 0 after the second, stays 0 after further not-taken updates (ctr floor 0).
- Aliasing: ENTRIES=16, train 0x100 taken, then taken update at 0x140 (same index, different tag) -> 0x100 misses (pcresult=0x104); 0x140 predicts its own target.
- Priority: predict hit with isjump=1, jump_target=0x300 -> pcresult=0x300. Also assert redirect, redirect_pc=0x400 -> pcresult=0x400. pc=0xFFFFFFFC, no hit -> pcresult=0x0.
- BP_STATS_EN defined: 5 updates with 2 flagged upd_mispred -> stat_updates=5, stat_mispred=2. Macro undefined -> both read 0.
